food_ctrl: RTL and testbench

FOOD_CTRL -- requirements
Module: food_ctrl

---
 rtl/food_ctrl.sv | 154 +++++++++++++++
 tb/tb_food_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/food_ctrl.sv
// food_ctrl: places food on a free cell of the snake playfield and flags when the head eats it.
// Latency: placement needs one full body-stream pass after a legal candidate; o_eat registers one cycle after the eating head element.
// Backpressure: none; the position stream is observed passively and never stalled, and i_success overrides everything.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   i_pos_x/y/first/last/valid       body position stream (head first, tail last)
//   i_success                        snake reached maximum length; freeze in DONE
//   o_eat                            one-cycle grow pulse to the snake
//   o_food_x/y, o_food_valid         food position and its display qualifier

module food_ctrl #(
  parameter int          GAME_WIDTH  = 30,
  parameter int          GAME_HEIGHT = 14,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] i_pos_x,
  input  logic [3:0] i_pos_y,
  input  logic       i_pos_first,
  input  logic       i_pos_last,
  input  logic       i_pos_valid,
  input  logic       i_success,
  output logic       o_eat,
  output logic [4:0] o_food_x,
  output logic [3:0] o_food_y,
  output logic       o_food_valid
);

  typedef enum logic [2:0] {
    PICK   = 3'd0,
    SYNC   = 3'd1,
    SCAN   = 3'd2,
    PLACED = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Playfield limits held at 6 bits so a 31-wide field still compares correctly.
  localparam logic [5:0] C_X_MAX = 6'(GAME_WIDTH);
  localparam logic [5:0] C_Y_MAX = 6'(GAME_HEIGHT);

  state_t      r_state;
  logic [15:0] r_lfsr;
  logic [4:0]  r_food_x;
  logic [3:0]  r_food_y;
  logic        r_food_valid;
  logic        r_eat;

  logic        w_lfsr_fb;
  logic [4:0]  w_cand_x;
  logic [3:0]  w_cand_y;
  logic [5:0]  w_cand_x6;
  logic [5:0]  w_cand_y6;
  logic        w_cand_ok;
  logic        w_hit;
  logic        w_head;

  // Fibonacci taps 16,14,13,11 (bits 15,13,12,10), shifted in at bit 0.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  assign w_cand_x  = r_lfsr[4:0];
  assign w_cand_y  = r_lfsr[8:5];
  assign w_cand_x6 = {1'b0, w_cand_x};
  assign w_cand_y6 = {2'b00, w_cand_y};

  // Candidate must sit strictly inside the walls.
  assign w_cand_ok = (w_cand_x6 >= 6'd1) && (w_cand_x6 <= C_X_MAX) &&
                     (w_cand_y6 >= 6'd1) && (w_cand_y6 <= C_Y_MAX);

  assign w_hit  = (i_pos_x == r_food_x) && (i_pos_y == r_food_y);
  assign w_head = i_pos_valid && i_pos_first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= PICK;
      r_lfsr       <= LFSR_SEED;
      r_food_x     <= 5'd0;
      r_food_y     <= 4'd0;
      r_food_valid <= 1'b0;
      r_eat        <= 1'b0;
    end else begin
      // The LFSR free-runs regardless of state so retries see fresh values.
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      r_eat  <= 1'b0;

      if (i_success) begin
        // Success wins over any eat happening on the same edge.
        r_state      <= DONE;
        r_food_valid <= 1'b0;
      end else begin
        case (r_state)
          PICK: begin
            if (w_cand_ok) begin
              r_food_x <= w_cand_x;
              r_food_y <= w_cand_y;
              r_state  <= SYNC;
            end
          end

          // Align to the head so the scan covers one complete body pass;
          // the head element itself is the first comparison.
          SYNC: begin
            if (w_head) begin
              if (w_hit) begin
                r_state <= PICK;
              end else if (i_pos_last) begin
                r_state      <= PLACED;
                r_food_valid <= 1'b1;
              end else begin
                r_state <= SCAN;
              end
            end
          end

          SCAN: begin
            if (i_pos_valid) begin
              if (w_hit) begin
                r_state <= PICK;
              end else if (i_pos_last) begin
                r_state      <= PLACED;
                r_food_valid <= 1'b1;
              end
            end
          end

          // Only the head can eat; body segments over the food are ignored.
          PLACED: begin
            if (w_head && w_hit) begin
              r_eat        <= 1'b1;
              r_food_valid <= 1'b0;
              r_state      <= PICK;
            end
          end

          DONE: begin
            r_food_valid <= 1'b0;
          end

          default: begin
            r_state      <= PICK;
            r_food_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_eat        = r_eat;
  assign o_food_x     = r_food_x;
  assign o_food_y     = r_food_y;
  assign o_food_valid = r_food_valid;

endmodule

// File: tb/tb_food_ctrl.sv
// tb_food_ctrl: directed scenarios for food_ctrl with hand-derived LFSR candidates.
// Latency: stimulus is applied and outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives the position stream directly.
//
// LFSR states from seed 16'hACE1 (hand-derived):
//   s0=ACE1 -> (1,7)   s1=59C3 -> (3,14)  s2=B387   s3=670F -> (15,8)
//   s4=CE1E -> (30,0) wall   s5=9C3C -> (28,1)

module tb_food_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] i_pos_x;
  logic [3:0] i_pos_y;
  logic       i_pos_first;
  logic       i_pos_last;
  logic       i_pos_valid;
  logic       i_success;
  logic       o_eat;
  logic [4:0] o_food_x;
  logic [3:0] o_food_y;
  logic       o_food_valid;

  int errors;
  int checks;

  food_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_pos_x      (i_pos_x),
    .i_pos_y      (i_pos_y),
    .i_pos_first  (i_pos_first),
    .i_pos_last   (i_pos_last),
    .i_pos_valid  (i_pos_valid),
    .i_success    (i_success),
    .o_eat        (o_eat),
    .o_food_x     (o_food_x),
    .o_food_y     (o_food_y),
    .o_food_valid (o_food_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic l,
                       input logic [4:0] x, input logic [3:0] y);
    i_pos_valid = v;
    i_pos_first = f;
    i_pos_last  = l;
    i_pos_x     = x;
    i_pos_y     = y;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    i_success = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (o_eat !== 1'b0) begin errors++; $display("FAIL reset_eat got=%b want=0", o_eat); end
    checks++; if (o_food_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", o_food_valid); end
    checks++; if (o_food_x !== 5'd0) begin errors++; $display("FAIL reset_x got=%0d want=0", o_food_x); end
    checks++; if (o_food_y !== 4'd0) begin errors++; $display("FAIL reset_y got=%0d want=0", o_food_y); end
  endtask

  // Length-1 snake at (8,8); seed candidate (1,7) is free.
  task automatic test_place();
    apply_reset();
    step();
    checks++; if (o_food_x !== 5'd1 || o_food_y !== 4'd7) begin errors++; $display("FAIL place_latch got=(%0d,%0d) want=(1,7)", o_food_x, o_food_y); end
    checks++; if (o_food_valid !== 1'b0) begin errors++; $display("FAIL place_pre_valid got=%b want=0", o_food_valid); end
    drive(1'b1, 1'b1, 1'b1, 5'd8, 4'd8);
    step();
    checks++; if (o_food_valid !== 1'b1) begin errors++; $display("FAIL place_valid got=%b want=1", o_food_valid); end
    checks++; if (o_food_x !== 5'd1 || o_food_y !== 4'd7) begin errors++; $display("FAIL place_pos got=(%0d,%0d) want=(1,7)", o_food_x, o_food_y); end
    checks++; if (o_eat !== 1'b0) begin errors++; $display("FAIL place_eat got=%b want=0", o_eat); end
  endtask

  // Tail sits on the seed candidate (1,7): rejected, next pick from s3 = (15,8).
  task automatic test_reject();
    apply_reset();
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd8, 4'd8);
    step();
    drive(1'b1, 1'b0, 1'b1, 5'd1, 4'd7);
    step();
    checks++; if (o_food_valid !== 1'b0) begin errors++; $display("FAIL reject_valid got=%b want=0", o_food_valid); end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
    step();
    checks++; if (o_food_x !== 5'd15 || o_food_y !== 4'd8) begin errors++; $display("FAIL reject_repick got=(%0d,%0d) want=(15,8)", o_food_x, o_food_y); end
    drive(1'b1, 1'b1, 1'b0, 5'd8, 4'd8);
    step();
    checks++; if (o_food_valid !== 1'b0) begin errors++; $display("FAIL reject_midscan_valid got=%b want=0", o_food_valid); end
    drive(1'b1, 1'b0, 1'b1, 5'd1, 4'd7);
    step();
    checks++; if (o_food_valid !== 1'b1) begin errors++; $display("FAIL reject_placed got=%b want=1", o_food_valid); end
    checks++; if (o_food_x !== 5'd15 || o_food_y !== 4'd8) begin errors++; $display("FAIL reject_pos got=(%0d,%0d) want=(15,8)", o_food_x, o_food_y); end
  endtask

  // Rejection one cycle later lands PICK on s4 = (30,0): wall row, retried; s5 = (28,1) accepted.
  task automatic test_wall_reject();
    apply_reset();
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd8, 4'd8);
    step();
    drive(1'b1, 1'b0, 1'b0, 5'd9, 4'd9);
    step();
    drive(1'b1, 1'b0, 1'b1, 5'd1, 4'd7);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
    step();
    checks++; if (o_food_x !== 5'd1 || o_food_y !== 4'd7) begin errors++; $display("FAIL wall_hold got=(%0d,%0d) want=(1,7)", o_food_x, o_food_y); end
    checks++; if (o_food_valid !== 1'b0) begin errors++; $display("FAIL wall_valid got=%b want=0", o_food_valid); end
    step();
    checks++; if (o_food_x !== 5'd28 || o_food_y !== 4'd1) begin errors++; $display("FAIL wall_repick got=(%0d,%0d) want=(28,1)", o_food_x, o_food_y); end
    drive(1'b1, 1'b1, 1'b0, 5'd8, 4'd8);
    step();
    drive(1'b1, 1'b0, 1'b1, 5'd1, 4'd7);
    step();
    checks++; if (o_food_valid !== 1'b1) begin errors++; $display("FAIL wall_placed got=%b want=1", o_food_valid); end
  endtask

  // Head eats (1,7); repeated head element must not pulse again.
  task automatic test_eat();
    apply_reset();
    step();
    drive(1'b1, 1'b1, 1'b1, 5'd3, 4'd3);
    step();
    checks++; if (o_food_valid !== 1'b1) begin errors++; $display("FAIL eat_pre_valid got=%b want=1", o_food_valid); end
    drive(1'b1, 1'b1, 1'b1, 5'd1, 4'd7);
    step();
    checks++; if (o_eat !== 1'b1) begin errors++; $display("FAIL eat_pulse got=%b want=1", o_eat); end
    checks++; if (o_food_valid !== 1'b0) begin errors++; $display("FAIL eat_valid_drop got=%b want=0", o_food_valid); end
    step();
    checks++; if (o_eat !== 1'b0) begin errors++; $display("FAIL eat_one_cycle got=%b want=0", o_eat); end
    checks++; if (o_food_x !== 5'd15 || o_food_y !== 4'd8) begin errors++; $display("FAIL eat_new_food got=(%0d,%0d) want=(15,8)", o_food_x, o_food_y); end
    step();
    checks++; if (o_food_valid !== 1'b1) begin errors++; $display("FAIL eat_new_valid got=%b want=1", o_food_valid); end
    checks++; if (o_eat !== 1'b0) begin errors++; $display("FAIL eat_repeat1 got=%b want=0", o_eat); end
    step();
    checks++; if (o_eat !== 1'b0) begin errors++; $display("FAIL eat_repeat2 got=%b want=0", o_eat); end
  endtask

  // Tail on the food does not eat.
  task automatic test_tail_no_eat();
    apply_reset();
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd3, 4'd3);
    step();
    drive(1'b1, 1'b0, 1'b1, 5'd2, 4'd2);
    step();
    checks++; if (o_food_valid !== 1'b1) begin errors++; $display("FAIL tail_placed got=%b want=1", o_food_valid); end
    drive(1'b1, 1'b0, 1'b1, 5'd1, 4'd7);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (o_eat !== 1'b0) begin errors++; $display("FAIL tail_eat cyc=%0d got=%b want=0", i, o_eat); end
      checks++; if (o_food_valid !== 1'b1) begin errors++; $display("FAIL tail_valid cyc=%0d got=%b want=1", i, o_food_valid); end
    end
  endtask

  // Success on the same edge as an eating head: DONE, no pulse, held for 100 cycles.
  task automatic test_success();
    apply_reset();
    step();
    drive(1'b1, 1'b1, 1'b1, 5'd3, 4'd3);
    step();
    drive(1'b1, 1'b1, 1'b1, 5'd1, 4'd7);
    i_success = 1'b1;
    step();
    checks++; if (o_eat !== 1'b0) begin errors++; $display("FAIL success_eat got=%b want=0", o_eat); end
    checks++; if (o_food_valid !== 1'b0) begin errors++; $display("FAIL success_valid got=%b want=0", o_food_valid); end
    i_success = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++; if (o_food_valid !== 1'b0 || o_eat !== 1'b0) begin errors++; $display("FAIL done_hold cyc=%0d valid=%b eat=%b want=0/0", i, o_food_valid, o_eat); end
    end
  endtask

  // Asynchronous reset mid-SCAN, then restart from the seed candidate.
  task automatic test_async_reset();
    apply_reset();
    step();
    drive(1'b1, 1'b1, 1'b0, 5'd8, 4'd8);
    step();
    checks++; if (o_food_x !== 5'd1) begin errors++; $display("FAIL arst_pre_x got=%0d want=1", o_food_x); end
    drive(1'b1, 1'b0, 1'b0, 5'd1, 4'd7);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (o_food_x !== 5'd0 || o_food_y !== 4'd0) begin errors++; $display("FAIL arst_pos got=(%0d,%0d) want=(0,0)", o_food_x, o_food_y); end
    checks++; if (o_food_valid !== 1'b0 || o_eat !== 1'b0) begin errors++; $display("FAIL arst_flags valid=%b eat=%b want=0/0", o_food_valid, o_eat); end
    drive(1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    checks++; if (o_food_x !== 5'd1 || o_food_y !== 4'd7) begin errors++; $display("FAIL arst_restart got=(%0d,%0d) want=(1,7)", o_food_x, o_food_y); end
    checks++; if (o_eat !== 1'b0) begin errors++; $display("FAIL arst_eat got=%b want=0", o_eat); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    i_success = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 4'd0);
    test_reset();
    test_place();
    test_reject();
    test_wall_reject();
    test_eat();
    test_tail_no_eat();
    test_success();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
